// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the mux scan controller and its settle timer.
package mux_scan_pkg;

    localparam int CHANNELS = 16;
    localparam int SEL_W    = 4;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    function automatic logic is_last_chan(input logic [SEL_W-1:0] s);
        return s == SEL_W'(CHANNELS - 1);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that holds off sampling until the external mux output has settled.
module settle_timer
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(SETTLE_CYCLES);
        end else if (run_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The last settle cycle is the one where the count reads 1.
    assign expired_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Sequences the select of an external 16:1 mux and captures its output bit by bit.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                mode,
    input  logic [SEL_W-1:0]    chan,
    input  logic                abort,
    input  logic                mux_out,
    output logic [SEL_W-1:0]    sel,
    output logic                busy,
    output logic                done,
    output logic [CHANNELS-1:0] data
);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                mode_q, mode_d;
    logic [CHANNELS-1:0] data_q, data_d;

    logic timer_load;
    logic timer_run;
    logic timer_expired;
    logic sample_en;
    logic clear_data;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timer_load),
        .run_i    (timer_run),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        mode_d     = mode_q;
        timer_load = 1'b0;
        timer_run  = 1'b0;
        sample_en  = 1'b0;
        clear_data = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_SETTLE;
                    mode_d     = mode;
                    sel_d      = mode ? chan : '0;
                    timer_load = 1'b1;
                    clear_data = ~mode;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_run = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_SAMPLE;
                    end
                end
            end
            ST_SAMPLE: begin
                // An abort here drops the pending sample as well as the scan.
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    sample_en = 1'b1;
                    if (mode_q || is_last_chan(sel_q)) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d      = sel_q + 1'b1;
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_data_bit
        assign data_d[gi] = clear_data                                ? 1'b0    :
                            (sample_en && (sel_q == SEL_W'(gi)))      ? mux_out :
                                                                        data_q[gi];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            mode_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            mode_q  <= mode_d;
            data_q  <= data_d;
        end
    end

    assign sel  = sel_q;
    assign busy = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
    assign done = (state_q == ST_DONE);
    assign data = data_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench: two controllers (settle 2 and settle 1), each driving a behavioural 16:1 mux.
module tb_mux_scan_ctrl;

    localparam int SA = 2;
    localparam int SB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_mode, a_abort, a_mux_out, a_busy, a_done;
    logic [3:0]  a_chan, a_sel;
    logic [15:0] a_data, a_in;
    logic        b_rst, b_start, b_mode, b_abort, b_mux_out, b_busy, b_done;
    logic [3:0]  b_chan, b_sel;
    logic [15:0] b_data, b_in;

    assign a_mux_out = a_in[a_sel];
    assign b_mux_out = b_in[b_sel];

    mux_scan_ctrl #(.SETTLE_CYCLES(SA)) dut_a (
        .clk(clk), .rst(a_rst), .start(a_start), .mode(a_mode), .chan(a_chan),
        .abort(a_abort), .mux_out(a_mux_out), .sel(a_sel), .busy(a_busy),
        .done(a_done), .data(a_data)
    );

    mux_scan_ctrl #(.SETTLE_CYCLES(SB)) dut_b (
        .clk(clk), .rst(b_rst), .start(b_start), .mode(b_mode), .chan(b_chan),
        .abort(b_abort), .mux_out(b_mux_out), .sel(b_sel), .busy(b_busy),
        .done(b_done), .data(b_data)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_data [2];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int inst, input logic r, input logic s, input logic m,
                         input logic [3:0] ch, input logic ab);
        if (inst == 0) begin
            a_rst = r; a_start = s; a_mode = m; a_chan = ch; a_abort = ab;
        end else begin
            b_rst = r; b_start = s; b_mode = m; b_chan = ch; b_abort = ab;
        end
    endtask

    task automatic set_in(input int inst, input logic [15:0] v);
        if (inst == 0) a_in = v;
        else           b_in = v;
    endtask

    task automatic read_out(input int inst, output logic [3:0] osel, output logic obusy,
                            output logic odone, output logic [15:0] odata);
        if (inst == 0) begin
            osel = a_sel; obusy = a_busy; odone = a_done; odata = a_data;
        end else begin
            osel = b_sel; obusy = b_busy; odone = b_done; odata = b_data;
        end
    endtask

    // One scan from the start edge; cycle c is the interval after the (c-1)th edge past start.
    task automatic run_scan(input int inst, input logic m, input logic [3:0] ch,
                            input int abort_at, input int start2_at, input int rst_at,
                            input int chg_at, input logic [15:0] chg_val,
                            input bit rnd_in, input bit abort_with_start, input string tag);
        int   s      = (inst == 0) ? SA : SB;
        int   per    = s + 1;
        int   dc     = m ? (s + 2) : (16 * per + 1);
        bit   ab_eff = (abort_at > 0) && (abort_at < dc);
        bit   rs_eff = (rst_at > 0) && (rst_at <= dc);
        int   last_c = ab_eff ? abort_at : (rs_eff ? rst_at : dc);
        int   end_c  = last_c + 1;
        logic [3:0]  osel;
        logic        obusy, odone;
        logic [15:0] odata;
        logic [15:0] cur_in;
        logic [3:0]  exp_sel;
        int          cc;
        int          n;
        drive(inst, 1'b0, 1'b1, m, ch, abort_with_start);
        tick();
        drive(inst, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        if (!m) exp_data[inst] = 16'h0000;
        for (int c = 1; c <= end_c; c++) begin
            if (c == chg_at) set_in(inst, chg_val);
            else if (rnd_in && ($urandom_range(3) == 0)) set_in(inst, 16'($urandom));
            read_out(inst, osel, obusy, odone, odata);
            if (rs_eff && (c > rst_at)) begin
                exp_sel = 4'd0;
            end else begin
                cc = (ab_eff && (c > abort_at)) ? abort_at : c;
                exp_sel = m ? ch : 4'(((cc - 1) / per > 15) ? 15 : (cc - 1) / per);
            end
            chk($sformatf("%s c%0d busy", tag, c), 16'(obusy), 16'((c < dc) && (c <= last_c)));
            chk($sformatf("%s c%0d done", tag, c), 16'(odone), 16'((c == dc) && (c <= last_c)));
            chk($sformatf("%s c%0d sel", tag, c), 16'(osel), 16'(exp_sel));
            chk($sformatf("%s c%0d data", tag, c), odata, exp_data[inst]);
            if (c == end_c) break;
            drive(inst, 1'(c == rst_at), 1'(c == start2_at), 1'($urandom_range(1)),
                  4'($urandom_range(15)), 1'(c == abort_at));
            cur_in = (inst == 0) ? a_in : b_in;
            if (rs_eff && (c == rst_at)) begin
                exp_data[inst] = 16'h0000;
            end else if (!(ab_eff && (c == abort_at))) begin
                if (m && (c == per)) begin
                    exp_data[inst][ch] = cur_in[ch];
                end else if (!m && (c % per == 0) && (c <= 16 * per)) begin
                    n = c / per - 1;
                    exp_data[inst][n] = cur_in[n];
                end
            end
            tick();
            drive(inst, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic idle_abort(input int inst, input string tag);
        logic [3:0]  osel;
        logic        obusy, odone;
        logic [15:0] odata;
        drive(inst, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        tick();
        drive(inst, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        read_out(inst, osel, obusy, odone, odata);
        chk({tag, " busy"}, 16'(obusy), 16'h0);
        chk({tag, " done"}, 16'(odone), 16'h0);
        chk({tag, " data"}, odata, exp_data[inst]);
    endtask

    initial begin
        int m, ch, dc, ab, st2, rs;
        a_in = 16'h0000;
        b_in = 16'h0000;
        drive(0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
        tick();
        tick();
        chk("reset a sel", 16'(a_sel), 16'h0);
        chk("reset a busy", 16'(a_busy), 16'h0);
        chk("reset a done", 16'(a_done), 16'h0);
        chk("reset a data", a_data, 16'h0);
        chk("reset b data", b_data, 16'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        exp_data[0] = 16'h0000;
        exp_data[1] = 16'h0000;
        tick();

        set_in(0, 16'hA5C3);
        run_scan(0, 1'b0, 4'd0, 0, 0, 0, 0, 16'h0, 1'b0, 1'b0, "full");
        chk("full final data", a_data, 16'hA5C3);

        set_in(0, 16'hA543);
        run_scan(0, 1'b1, 4'd7, 0, 0, 0, 0, 16'h0, 1'b0, 1'b0, "single");
        chk("single final data", a_data, 16'hA543);

        set_in(0, 16'hA5C3);
        run_scan(0, 1'b0, 4'd0, 16, 0, 0, 0, 16'h0, 1'b0, 1'b0, "abort_ch5");
        chk("abort_ch5 final data", a_data, 16'h0003);
        idle_abort(0, "abort_idle");

        run_scan(0, 1'b0, 4'd0, 0, 10, 0, 0, 16'h0, 1'b0, 1'b0, "restart_ignored");
        chk("restart_ignored data", a_data, 16'hA5C3);

        run_scan(0, 1'b0, 4'd0, 0, 0, 20, 0, 16'h0, 1'b0, 1'b0, "rst_mid");
        chk("rst_mid data", a_data, 16'h0000);
        set_in(0, 16'h3C5A);
        run_scan(0, 1'b0, 4'd0, 0, 0, 0, 0, 16'h0, 1'b0, 1'b0, "after_rst");
        chk("after_rst data", a_data, 16'h3C5A);

        set_in(0, 16'h0000);
        run_scan(0, 1'b1, 4'd2, 0, 0, 0, 0, 16'h0, 1'b0, 1'b1, "start_abort_idle");
        set_in(0, 16'hFFFF);
        run_scan(0, 1'b1, 4'd9, SA + 2, 0, 0, 0, 16'h0, 1'b0, 1'b0, "abort_in_done");

        set_in(1, 16'h0000);
        run_scan(1, 1'b0, 4'd0, 0, 0, 0, 7, 16'h0008, 1'b0, 1'b0, "settle1_rise");
        chk("settle1_rise data", b_data, 16'h0008);
        set_in(1, 16'hFFFF);
        run_scan(1, 1'b0, 4'd0, 0, 0, 0, 7, 16'hFFF7, 1'b0, 1'b0, "settle1_fall");
        chk("settle1_fall data", b_data, 16'hFFF7);

        for (int i = 0; i < 24; i++) begin
            int inst;
            inst = (i % 4 == 3) ? 1 : 0;
            m  = int'($urandom_range(1));
            ch = int'($urandom_range(15));
            dc = (m != 0) ? (((inst == 0) ? SA : SB) + 2) : (16 * (((inst == 0) ? SA : SB) + 1) + 1);
            ab  = ($urandom_range(2) == 0) ? int'($urandom_range(dc, 1)) : 0;
            st2 = ($urandom_range(1) == 0) ? int'($urandom_range(dc, 1)) : 0;
            rs  = (ab == 0 && $urandom_range(5) == 0) ? int'($urandom_range(dc, 1)) : 0;
            if (st2 == ab) st2 = 0;
            set_in(inst, 16'($urandom));
            run_scan(inst, 1'(m), 4'(ch), ab, st2, rs, 0, 16'h0, 1'b1, 1'($urandom_range(1)),
                     $sformatf("rnd%0d", i));
            if ($urandom_range(1) == 0) idle_abort(inst, $sformatf("rnd%0d idle_abort", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, the number of cycles sel is held stable before each sample (legal range 1..15).
REQ-002 SHALL have one clock and a synchronous, active-high reset; the clock and reset ports are named as the codebase does.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port start  input  1  request a scan; accepted only in IDLE.
REQ-006 SHALL have port mode  input  1  0 = full sweep of channels 0..15, 1 = single channel; sampled with start.
REQ-007 SHALL have port chan  input  4  channel for single mode; sampled with start.
REQ-008 SHALL have port abort  input  1  terminate the scan in progress.
REQ-009 SHALL have port mux_out  input  1  output of the downstream 16:1 mux, same clock domain.
REQ-010 SHALL have port sel  output  4  select driven to the 16:1 mux.
REQ-011 SHALL have port busy  output  1  high in SETTLE and SAMPLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse on scan completion.
REQ-013 SHALL have port data  output  16  captured word; bit n holds the mux_out value sampled with sel = n.

Function
REQ-014 SHALL implement a state machine with states IDLE, SETTLE, SAMPLE and DONE.
REQ-015 IDLE, start=1: SHALL move to SETTLE, latch mode, and load sel (0 in full mode, chan in single mode) and the settle counter.
REQ-016 Start accepted in full mode: SHALL clear data to 0 on the same edge; single mode leaves all data bits other than the target unchanged.
REQ-017 SETTLE: SHALL last exactly SETTLE_CYCLES cycles, then move to SAMPLE.
REQ-018 SAMPLE: SHALL last one cycle; the edge ending it writes mux_out into data[sel].
REQ-019 After SAMPLE: full mode with sel<15 SHALL increment sel and return to SETTLE; sel=15 or single mode SHALL go to DONE.
REQ-020 DONE: SHALL assert done for exactly that cycle, then return to IDLE; sel holds its last value.
REQ-021 Latency: full sweep SHALL raise done 16*(SETTLE_CYCLES+1)+1 cycles after the start edge; single channel SHALL take SETTLE_CYCLES+2 cycles.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE; no queuing.
REQ-023 abort=1 in SETTLE or SAMPLE SHALL return to IDLE next edge; no done pulse, and no sample is written on that edge.
REQ-024 Partial data SHALL be retained after an abort.
REQ-025 abort SHALL be ignored in IDLE and DONE.
REQ-026 abort and start both high in IDLE: start SHALL win.
REQ-027 sel SHALL be 4 bits; the increment never wraps because DONE is taken at 15.
REQ-028 The settle counter SHALL be 4 bits and count down to 1.

Reset
REQ-029 rst SHALL force state IDLE, sel=0, busy=0, done=0, data=0, and settle counter 0 on the next rising edge.
REQ-030 rst SHALL take priority over start and abort, including mid-scan.

Structure
REQ-031 Package mux_scan_pkg SHALL hold the state enum, CHANNELS=16, SEL_W=4 and CNT_W=4.
REQ-032 SHALL instantiate one sub-module, settle_timer (load, count-down, expire flag).
REQ-033 SHALL contain no mux logic of its own; the 16:1 mux is external.

Verification
REQ-034 Bench SHALL pair the DUT with a 16:1 mux, in=16'hA5C3, SETTLE_CYCLES=2; start, mode=0 -> done at cycle 49, data=16'hA5C3, busy high cycles 1..48.
REQ-035 Bench SHALL cover single mode: data preloaded 16'hA5C3, in[7]=0, chan=7, mode=1 -> done at cycle 4, data=16'hA543.
REQ-036 Bench SHALL cover abort: abort during channel 5 SETTLE -> IDLE next cycle, no done, data[4:0]=in[4:0], data[15:5]=0.
REQ-037 Bench SHALL cover a second start at cycle 10 of a full sweep -> ignored, single done at cycle 49.
REQ-038 Bench SHALL cover rst at cycle 20 of a full sweep -> next cycle all outputs 0, state IDLE; a fresh start completes normally.
REQ-039 Bench SHALL cover SETTLE_CYCLES=1 with in changed while sel=3 is settling -> data[3] equals the value present at SAMPLE.
